// File: rtl/network_output_classifier_pkg.sv
// Shared constants and class encoding for the aux-channel output classifier.
// Class index n always names aux channel n.
package network_output_classifier_pkg;

    localparam int NUM_AUX    = 4;
    localparam int DATA_W_DEF = 12;
    localparam int CLS_W      = 2;

    typedef enum logic [CLS_W-1:0] {
        CLS_AUX0 = 2'd0,
        CLS_AUX1 = 2'd1,
        CLS_AUX2 = 2'd2,
        CLS_AUX3 = 2'd3
    } cls_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/aux_argmax4.sv
// Combinational 4-way unsigned maximum; on equal values the lower channel index wins.
module aux_argmax4
    import network_output_classifier_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_avg0,
    input  logic [DATA_W-1:0] i_avg1,
    input  logic [DATA_W-1:0] i_avg2,
    input  logic [DATA_W-1:0] i_avg3,
    output cls_e              o_idx,
    output logic [DATA_W-1:0] o_max
);

    cls_e              w_idx01;
    cls_e              w_idx23;
    logic [DATA_W-1:0] w_max01;
    logic [DATA_W-1:0] w_max23;

    // Pairwise tournament; strict '>' keeps the lower index on ties at every level
    always_comb begin
        w_idx01 = CLS_AUX0;
        w_max01 = i_avg0;
        w_idx23 = CLS_AUX2;
        w_max23 = i_avg2;
        o_idx   = CLS_AUX0;
        o_max   = i_avg0;
        if (i_avg1 > i_avg0) begin
            w_idx01 = CLS_AUX1;
            w_max01 = i_avg1;
        end else begin
            w_idx01 = CLS_AUX0;
            w_max01 = i_avg0;
        end
        if (i_avg3 > i_avg2) begin
            w_idx23 = CLS_AUX3;
            w_max23 = i_avg3;
        end else begin
            w_idx23 = CLS_AUX2;
            w_max23 = i_avg2;
        end
        if (w_max23 > w_max01) begin
            o_idx = w_idx23;
            o_max = w_max23;
        end else begin
            o_idx = w_idx01;
            o_max = w_max01;
        end
    end

endmodule

// File: rtl/network_output_classifier.sv
// Windowed-average classifier: averages four aux channels per window, picks the
// strongest, and only switches network_output after enough agreeing windows.
module network_output_classifier
    import network_output_classifier_pkg::*;
#(
    parameter int WIN_LOG2   = 3,
    parameter int STABLE_CNT = 4,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] MEASURED_AUX0,
    input  logic [DATA_W-1:0] MEASURED_AUX1,
    input  logic [DATA_W-1:0] MEASURED_AUX2,
    input  logic [DATA_W-1:0] MEASURED_AUX3,
    input  logic [DATA_W-1:0] threshold,
    output logic [1:0]        network_output,
    output logic              output_valid,
    output logic              class_change
);

    localparam int                  ACC_W      = DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST   = '1;
    localparam logic [3:0]          STABLE_THR = 4'(STABLE_CNT);

    logic [DATA_W-1:0]   w_aux [NUM_AUX];
    logic [ACC_W-1:0]    w_sum [NUM_AUX];
    logic [ACC_W-1:0]    r_acc [NUM_AUX];
    logic [DATA_W-1:0]   r_avg [NUM_AUX];
    logic [WIN_LOG2-1:0] r_cnt;
    logic                w_win_end;
    logic                r_s1_vld;
    logic                r_s2_vld;
    cls_e                w_cand;
    logic [DATA_W-1:0]   w_max;
    cls_e                r_cand;
    logic [DATA_W-1:0]   r_max_avg;
    cls_e                r_last_cand;
    cls_e                w_last_nxt;
    logic [3:0]          r_stable;
    logic [3:0]          w_stable_nxt;
    cls_e                r_net;
    cls_e                w_net_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_change;
    logic                w_change_nxt;

    // Accumulator inputs; the sum includes the current sample so the closing sample is counted
    always_comb begin
        w_aux[0] = MEASURED_AUX0;
        w_aux[1] = MEASURED_AUX1;
        w_aux[2] = MEASURED_AUX2;
        w_aux[3] = MEASURED_AUX3;
        for (int i = 0; i < NUM_AUX; i++) begin
            w_sum[i] = r_acc[i] + ACC_W'(w_aux[i]);
        end
        w_win_end = sample_valid && (r_cnt == CNT_LAST);
    end

    // Stage 1: accumulate, and on the last sample of a window latch averages and clear
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_cnt    <= '0;
            r_s1_vld <= 1'b0;
            for (int i = 0; i < NUM_AUX; i++) begin
                r_acc[i] <= '0;
                r_avg[i] <= '0;
            end
        end else begin
            r_s1_vld <= w_win_end;
            if (sample_valid) begin
                r_cnt <= r_cnt + WIN_LOG2'(1);
                for (int i = 0; i < NUM_AUX; i++) begin
                    if (w_win_end) begin
                        r_acc[i] <= '0;
                        r_avg[i] <= DATA_W'(w_sum[i] >> WIN_LOG2);
                    end else begin
                        r_acc[i] <= w_sum[i];
                    end
                end
            end
        end
    end

    aux_argmax4 #(.DATA_W(DATA_W)) u_argmax (
        .i_avg0 (r_avg[0]),
        .i_avg1 (r_avg[1]),
        .i_avg2 (r_avg[2]),
        .i_avg3 (r_avg[3]),
        .o_idx  (w_cand),
        .o_max  (w_max)
    );

    // Stage 2: register the winning channel and its average
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_s2_vld  <= 1'b0;
            r_cand    <= CLS_AUX0;
            r_max_avg <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_cand    <= w_cand;
                r_max_avg <= w_max;
            end
        end
    end

    // Stage 3 decision; a below-threshold window also breaks the agreement run
    always_comb begin
        w_stable_nxt = r_stable;
        w_last_nxt   = r_last_cand;
        w_valid_nxt  = r_valid;
        w_net_nxt    = r_net;
        w_change_nxt = 1'b0;
        if (r_s2_vld) begin
            if (r_max_avg < threshold) begin
                w_valid_nxt  = 1'b0;
                w_stable_nxt = 4'd0;
            end else begin
                w_valid_nxt = 1'b1;
                if (r_cand == r_last_cand) begin
                    w_stable_nxt = sat_inc4(r_stable);
                end else begin
                    w_stable_nxt = 4'd1;
                    w_last_nxt   = r_cand;
                end
                if ((w_stable_nxt >= STABLE_THR) && (r_cand != r_net)) begin
                    w_net_nxt    = r_cand;
                    w_change_nxt = 1'b1;
                end else begin
                    w_net_nxt    = r_net;
                    w_change_nxt = 1'b0;
                end
            end
        end else begin
            w_change_nxt = 1'b0;
        end
    end

    // Stage 3 state and registered outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_stable    <= 4'd0;
            r_last_cand <= CLS_AUX0;
            r_net       <= CLS_AUX0;
            r_valid     <= 1'b0;
            r_change    <= 1'b0;
        end else begin
            r_stable    <= w_stable_nxt;
            r_last_cand <= w_last_nxt;
            r_net       <= w_net_nxt;
            r_valid     <= w_valid_nxt;
            r_change    <= w_change_nxt;
        end
    end

    assign network_output = r_net;
    assign output_valid   = r_valid;
    assign class_change   = r_change;

endmodule

// File: tb/tb_network_output_classifier.sv
// Directed bench for network_output_classifier (WIN_LOG2=3, STABLE_CNT=4):
// table of window patterns plus hand-timed sequences for pipeline/reset corners.
module tb_network_output_classifier;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] aux0, aux1, aux2, aux3;
    logic [11:0] thr;
    logic [1:0]  network_output;
    logic        output_valid;
    logic        class_change;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int chg_base;

    typedef struct {
        bit          rst;
        logic [11:0] a0, a1, a2, a3;
        logic [11:0] th;
        int          nsets;
        logic [1:0]  net;
        logic        vld;
        int          chg;
    } vec_t;

    vec_t vecs[12];

    network_output_classifier #(.WIN_LOG2(3), .STABLE_CNT(4), .DATA_W(12)) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .sample_valid   (sample_valid),
        .MEASURED_AUX0  (aux0),
        .MEASURED_AUX1  (aux1),
        .MEASURED_AUX2  (aux2),
        .MEASURED_AUX3  (aux3),
        .threshold      (thr),
        .network_output (network_output),
        .output_valid   (output_valid),
        .class_change   (class_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (class_change === 1'b1) chg_cnt <= chg_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_aux(input logic [11:0] a0, a1, a2, a3);
        aux0 = a0; aux1 = a1; aux2 = a2; aux3 = a3;
    endtask

    // Returns at the first falling edge after the last sample was captured
    task automatic send_sets(input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            if (!b2b || i == n - 1) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input bit sv_during, input bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        sample_valid = sv_during;
        repeat (2) @(negedge clk);
        if (chk) begin
            check("rst_net", {30'd0, network_output}, 32'd0);
            check("rst_valid", {31'd0, output_valid}, 32'd0);
            check("rst_change", {31'd0, class_change}, 32'd0);
        end
        rst_n = 1'b1;
        sample_valid = 1'b0;
    endtask

    task automatic flush();
        repeat (6) @(negedge clk);
    endtask

    // Expects class_change only in the third cycle after the closing sample
    task automatic check_timing(input string tag, input logic [1:0] exp_net);
        check({tag, "_cc_t1"}, {31'd0, class_change}, 32'd0);
        @(negedge clk);
        check({tag, "_cc_t2"}, {31'd0, class_change}, 32'd0);
        @(negedge clk);
        check({tag, "_cc_t3"}, {31'd0, class_change}, 32'd1);
        check({tag, "_net_t3"}, {30'd0, network_output}, {30'd0, exp_net});
        check({tag, "_vld_t3"}, {31'd0, output_valid}, 32'd1);
        @(negedge clk);
        check({tag, "_cc_t4"}, {31'd0, class_change}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        sample_valid = 1'b0;
        thr = 12'h100;
        set_aux(12'h000, 12'h000, 12'h000, 12'h000);

        vecs[0]  = '{1'b1, 12'h050, 12'h050, 12'h800, 12'h050, 12'h100, 32, 2'd2, 1'b1, 1};
        vecs[1]  = '{1'b0, 12'h050, 12'h050, 12'h800, 12'h050, 12'h900,  8, 2'd2, 1'b0, 0};
        vecs[2]  = '{1'b0, 12'h050, 12'h050, 12'h800, 12'h050, 12'h100,  8, 2'd2, 1'b1, 0};
        vecs[3]  = '{1'b1, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 12'h100, 64, 2'd0, 1'b0, 0};
        vecs[4]  = '{1'b1, 12'h000, 12'h400, 12'h000, 12'h400, 12'h100, 32, 2'd1, 1'b1, 1};
        vecs[5]  = '{1'b1, 12'h400, 12'h000, 12'h000, 12'h000, 12'h100, 24, 2'd0, 1'b1, 0};
        vecs[6]  = '{1'b0, 12'h000, 12'h000, 12'h000, 12'h400, 12'h100, 24, 2'd0, 1'b1, 0};
        vecs[7]  = '{1'b0, 12'h000, 12'h000, 12'h000, 12'h400, 12'h100,  8, 2'd3, 1'b1, 1};
        vecs[8]  = '{1'b1, 12'h000, 12'h400, 12'h000, 12'h000, 12'h100, 24, 2'd0, 1'b1, 0};
        vecs[9]  = '{1'b0, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 12'h100,  8, 2'd0, 1'b0, 0};
        vecs[10] = '{1'b0, 12'h000, 12'h400, 12'h000, 12'h000, 12'h100, 24, 2'd0, 1'b1, 0};
        vecs[11] = '{1'b0, 12'h000, 12'h400, 12'h000, 12'h000, 12'h100,  8, 2'd1, 1'b1, 1};

        do_reset(1'b0, 1'b1);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].rst) do_reset(1'b0, 1'b0);
            thr = vecs[v].th;
            set_aux(vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].a3);
            chg_base = chg_cnt;
            send_sets(vecs[v].nsets, 1'b0);
            flush();
            check($sformatf("vec%0d_net", v), {30'd0, network_output}, {30'd0, vecs[v].net});
            check($sformatf("vec%0d_valid", v), {31'd0, output_valid}, {31'd0, vecs[v].vld});
            check($sformatf("vec%0d_changes", v), chg_cnt - chg_base, vecs[v].chg);
        end

        // Dominant AUX2: change lands exactly in the third cycle after set 32
        do_reset(1'b0, 1'b0);
        thr = 12'h100;
        set_aux(12'h050, 12'h050, 12'h800, 12'h050);
        chg_base = chg_cnt;
        send_sets(32, 1'b0);
        check_timing("dom2", 2'd2);
        flush();
        check("dom2_changes", chg_cnt - chg_base, 32'd1);

        // Alternating winners never build a run longer than one window
        do_reset(1'b0, 1'b0);
        chg_base = chg_cnt;
        for (int w = 0; w < 10; w++) begin
            if (w % 2 == 0) set_aux(12'h400, 12'h000, 12'h000, 12'h000);
            else            set_aux(12'h000, 12'h000, 12'h000, 12'h400);
            send_sets(8, 1'b0);
        end
        flush();
        check("alt_changes", chg_cnt - chg_base, 32'd0);
        check("alt_net", {30'd0, network_output}, 32'd0);
        send_sets(16, 1'b0);
        flush();
        check("alt_run3_changes", chg_cnt - chg_base, 32'd0);
        send_sets(8, 1'b0);
        check_timing("alt_run4", 2'd3);

        // Back-to-back full-scale samples; threshold 0xFFF passes only if avg3 is exact
        do_reset(1'b0, 1'b0);
        thr = 12'hFFF;
        set_aux(12'h000, 12'h000, 12'h000, 12'hFFF);
        chg_base = chg_cnt;
        send_sets(32, 1'b1);
        check_timing("b2b", 2'd3);
        flush();
        check("b2b_changes", chg_cnt - chg_base, 32'd1);
        thr = 12'h100;

        // Partial window then reset with a coincident strobe: both must be discarded
        set_aux(12'h000, 12'h000, 12'hFFF, 12'h000);
        send_sets(5, 1'b0);
        set_aux(12'h000, 12'h600, 12'h000, 12'h000);
        do_reset(1'b1, 1'b1);
        chg_base = chg_cnt;
        send_sets(32, 1'b0);
        check_timing("midrst", 2'd1);
        flush();
        check("midrst_changes", chg_cnt - chg_base, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/network_output_classifier.md
NETWORK_OUTPUT_CLASSIFIER -- requirements
Module: network_output_classifier

Interface
REQ-001 Parameter WIN_LOG2, default 3, log2 of samples averaged per window (window = 8 sample sets).
REQ-002 Parameter STABLE_CNT, default 4, consecutive agreeing windows required before network_output changes; legal range 1..15.
REQ-003 Parameter DATA_W, default 12, XADC aux sample width.
REQ-004 S_AXI_ACLK  in  1  sole clock; all state updates on rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 sample_valid  in  1  one-cycle strobe; MEASURED_AUX0..3 hold a fresh, coherent sample set.
REQ-007 MEASURED_AUX0, MEASURED_AUX1, MEASURED_AUX2, MEASURED_AUX3  in  DATA_W each  unsigned aux channel samples.
REQ-008 threshold  in  DATA_W  minimum window average for a channel to count as an active class.
REQ-009 network_output  out  2  index of the stable winning channel; feeds LED/register decode.
REQ-010 output_valid  out  1  high while the last decided window's maximum average >= threshold.
REQ-011 class_change  out  1  one-cycle pulse when network_output changes value.

Function
REQ-012 Per channel, an accumulator of DATA_W+WIN_LOG2 bits shall add the sample on every sample_valid; no overflow is possible.
REQ-013 A window counter of WIN_LOG2 bits shall increment on each sample_valid and wrap from 2^WIN_LOG2-1 to 0.
REQ-014 On the sample_valid at count 2^WIN_LOG2-1 (cycle T), stage 1 shall register avg_n = (acc_n + sample_n) >> WIN_LOG2 for every channel and load all accumulators with 0 in the same edge; the avg registers are visible at T+1.
REQ-015 Stage 2 (visible T+2) shall register candidate = argmax(avg0..3) and max_avg; ties resolve to the lowest index.
REQ-016 Stage 3 (visible T+3) decision:
 - max_avg < threshold: output_valid <= 0, stable counter <= 0, network_output held, no class_change.
 - otherwise output_valid <= 1; if candidate == last_candidate, stable counter saturates-increments, else stable counter <= 1 and last_candidate <= candidate.
 - when the new stable counter value >= STABLE_CNT and candidate != network_output: network_output <= candidate and class_change = 1 for exactly that cycle.
REQ-017 The three stages form a pipeline with no stalls; a new window completing while stages 2/3 are busy shall be processed normally (minimum window spacing of 2^WIN_LOG2 cycles ensures no overlap, but no sample_valid shall ever be dropped).
REQ-018 sample_valid on consecutive cycles shall be accepted every cycle.
REQ-019 With STABLE_CNT=1 a class change shall occur on the first window whose candidate differs and is above threshold.
REQ-020 Changes to threshold take effect at the next stage-3 evaluation; mid-window changes affect no accumulated data.

Reset
REQ-021 While S_AXI_ARESETN is low at a clock edge: accumulators, window counter, avg registers, candidate, max_avg, last_candidate and stable counter clear to 0; network_output = 2'b00, output_valid = 0, class_change = 0.
REQ-022 Reset mid-window or mid-pipeline shall discard all partial data; the first window after reset begins with the first post-reset sample_valid.
REQ-023 sample_valid coincident with active reset shall be ignored.

Structure
REQ-024 A shared package shall hold NUM_AUX = 4, DATA_W default, class index width (2) and the class encoding of channel n = n.
REQ-025 One sub-module, aux_argmax4, shall implement the combinational 4-way unsigned max with lowest-index tie break; it feeds the stage-2 registers.

Verification (WIN_LOG2=3, STABLE_CNT=4, threshold=0x100)
REQ-026 Reset, then 32 sample sets with AUX2=0x800, others=0x050 -> class_change exactly once, 3 cycles after the 32nd sample_valid; network_output=2, output_valid=1.
REQ-027 All channels=0x0FF for 64 sets -> output_valid=0 after first window, network_output stays 0, no class_change.
REQ-028 AUX1=AUX3=0x400, others 0 for 32 sets -> tie resolves to 1; network_output=1.
REQ-029 Alternate winner per window (AUX0 then AUX3, 8 sets each) for 80 sets -> stable counter never exceeds 1, network_output unchanged, no class_change.
REQ-030 Back-to-back sample_valid every cycle, AUX3=0xFFF all channels else 0, 32 sets -> avg3=0xFFF with no overflow, network_output=3 at cycle T+3 after set 32.
REQ-031 Reset asserted after 5 sets of a window, then 32 sets of AUX1=0x600 -> first window counts only post-reset samples; network_output=1 after the 4th full window.
